busca_instrucao: RTL



---
 rtl/busca_instrucao_pkg.sv | 14 +
 rtl/busca_instrucao_if.sv | 26 ++
 rtl/contador_programa.sv | 29 ++
 rtl/busca_instrucao.sv | 74 +++++++
 4 files changed

// File: rtl/busca_instrucao_pkg.sv
// Shared widths and fetch-stage state encoding for the instruction fetch unit.
package busca_instrucao_pkg;

  localparam int unsigned LARGURA_DADO     = 8;
  localparam int unsigned LARGURA_OPCODE   = 3;
  localparam int unsigned LARGURA_IMEDIATO = 5;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    BUSCA   = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Memory, control and decode-side signals of the fetch unit; master is the fetch unit itself.
interface busca_instrucao_if;

  logic [busca_instrucao_pkg::LARGURA_DADO-1:0]     memEndereco;
  logic                                             memRequisicao;
  logic                                             memPronto;
  logic [busca_instrucao_pkg::LARGURA_DADO-1:0]     memDado;
  logic                                             desvio;
  logic [busca_instrucao_pkg::LARGURA_DADO-1:0]     alvoDesvio;
  logic                                             parada;
  logic                                             instrucaoValida;
  logic [busca_instrucao_pkg::LARGURA_OPCODE-1:0]   opcode;
  logic [busca_instrucao_pkg::LARGURA_IMEDIATO-1:0] imediato5;
  logic [busca_instrucao_pkg::LARGURA_DADO-1:0]     pcInstrucao;

  modport master (
    output memEndereco, memRequisicao, instrucaoValida, opcode, imediato5, pcInstrucao,
    input  memPronto, memDado, desvio, alvoDesvio, parada
  );

  modport slave (
    input  memEndereco, memRequisicao, instrucaoValida, opcode, imediato5, pcInstrucao,
    output memPronto, memDado, desvio, alvoDesvio, parada
  );

endinterface

// File: rtl/contador_programa.sv
// Program counter: branch load has priority over increment; otherwise holds.
module contador_programa
  import busca_instrucao_pkg::*;
#(
  parameter logic [LARGURA_DADO-1:0] PC_RESET = 8'h00
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    carga,
  input  logic [LARGURA_DADO-1:0] alvo,
  input  logic                    incrementa,
  output logic [LARGURA_DADO-1:0] pc
);

  logic [LARGURA_DADO-1:0] pc_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_q <= PC_RESET;
    end else if (carga) begin
      pc_q <= alvo;
    end else if (incrementa) begin
      pc_q <= pc_q + 8'd1;  // natural wrap 8'hFF -> 8'h00
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: requests a byte at PC, presents its decoded fields until accepted,
// and flushes on a taken branch.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter logic [LARGURA_DADO-1:0] PC_RESET = 8'h00
) (
  input  logic                clock,
  input  logic                resetN,
  busca_instrucao_if.master   bus
);

  estado_t                 estado_q, estado_d;
  logic [LARGURA_DADO-1:0] pc;
  logic [LARGURA_DADO-1:0] instr_q;
  logic [LARGURA_DADO-1:0] pc_instr_q;
  logic                    captura;

  // A branch in the same cycle as a memory response discards the response.
  assign captura = (estado_q == BUSCA) && bus.memPronto && !bus.desvio;

  contador_programa #(
    .PC_RESET (PC_RESET)
  ) u_contador_programa (
    .clock      (clock),
    .resetN     (resetN),
    .carga      (bus.desvio),
    .alvo       (bus.alvoDesvio),
    .incrementa (captura),
    .pc         (pc)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    if (bus.desvio) begin
      estado_d = BUSCA;
    end else begin
      unique case (estado_q)
        OCIOSO:  estado_d = BUSCA;
        BUSCA:   estado_d = bus.memPronto ? ENTREGA : BUSCA;
        ENTREGA: estado_d = bus.parada ? ENTREGA : BUSCA;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      instr_q    <= '0;
      pc_instr_q <= '0;
    end else if (captura) begin
      instr_q    <= bus.memDado;
      pc_instr_q <= pc;
    end
  end

  always_comb begin
    bus.memEndereco     = pc;
    bus.memRequisicao   = (estado_q == BUSCA);
    bus.instrucaoValida = (estado_q == ENTREGA);
    bus.opcode          = instr_q[7:5];
    bus.imediato5       = instr_q[4:0];
    bus.pcInstrucao     = pc_instr_q;
  end

endmodule
